// File: rtl/alu_issue.sv
// alu_issue: two-stage RV32 ALU issue (decode/issue register, ALU result register)
module alu_issue (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic [31:0] data1_o,
    output logic [31:0] data2_o,
    output logic [3:0]  ALUCtrl_o,
    input  logic [31:0] alu_data_i,
    input  logic        alu_flag_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o,
    output logic        flag_o,
    output logic [3:0]  op_o,
    input  logic        flush_i,
    output logic        illegal_o
);
    localparam logic [3:0] OP_ADDI = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_NONE = 4'b1111;

    typedef enum logic [1:0] {IDLE, EXEC, MULW} state_t;

    state_t      state, state_nxt;
    logic [3:0]  s1_ctrl;
    logic [31:0] s1_d1, s1_d2;
    logic        s1_valid, eligible, xfer, hs, accept;
    logic        s2_valid, s2_flag;
    logic [31:0] s2_result;
    logic [3:0]  s2_op;
    logic        illegal_q;
    logic [3:0]  dec_ctrl;
    logic [31:0] dec_d2;
    logic        dec_legal;
    logic        unused_bits;

    wire [6:0]  opcode = instr_i[6:0];
    wire [2:0]  funct3 = instr_i[14:12];
    wire [6:0]  funct7 = instr_i[31:25];
    wire [31:0] imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    wire [31:0] imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};

    assign unused_bits = ^instr_i[19:15];

    // Decode the incoming instruction into an ALU op, second operand and legality
    always_comb begin
        dec_ctrl  = OP_NONE;
        dec_d2    = 32'd0;
        dec_legal = 1'b0;
        if (opcode == 7'b0110011) begin
            dec_d2    = rs2_data_i;
            dec_legal = 1'b1;
            if (funct7 == 7'b0000000 && funct3 == 3'b000) dec_ctrl = OP_ADD;
            else if (funct7 == 7'b0100000 && funct3 == 3'b000) dec_ctrl = OP_SUB;
            else if (funct7 == 7'b0000000 && funct3 == 3'b111) dec_ctrl = OP_AND;
            else if (funct7 == 7'b0000000 && funct3 == 3'b110) dec_ctrl = OP_OR;
            else if (funct7 == 7'b0000001 && funct3 == 3'b000) dec_ctrl = OP_MUL;
            else dec_legal = 1'b0;
        end else if (opcode == 7'b0010011 && funct3 == 3'b000) begin
            dec_ctrl  = OP_ADDI;
            dec_d2    = imm_i;
            dec_legal = 1'b1;
        end else if (opcode == 7'b0000011 && funct3 == 3'b010) begin
            dec_ctrl  = OP_LW;
            dec_d2    = imm_i;
            dec_legal = 1'b1;
        end else if (opcode == 7'b0100011 && funct3 == 3'b010) begin
            dec_ctrl  = OP_SW;
            dec_d2    = imm_s;
            dec_legal = 1'b1;
        end
    end

    assign s1_valid    = state != IDLE;
    assign eligible    = (state == EXEC && s1_ctrl != OP_MUL) || state == MULW;
    assign xfer        = eligible && (!s2_valid || out_ready_i) && !flush_i;
    assign in_ready_o  = !rst_i && (!s1_valid || xfer);
    assign hs          = in_valid_i && in_ready_o && !flush_i;
    assign accept      = hs && dec_legal;

    assign ALUCtrl_o   = s1_valid ? s1_ctrl : OP_NONE;
    assign data1_o     = s1_valid ? s1_d1 : 32'd0;
    assign data2_o     = s1_valid ? s1_d2 : 32'd0;
    assign out_valid_o = s2_valid;
    assign result_o    = s2_result;
    assign flag_o      = s2_flag;
    assign op_o        = s2_op;
    assign illegal_o   = illegal_q;

    // Issue FSM: flush dominates, a new accept refills, transfer drains, mul waits one extra cycle
    always_comb begin
        state_nxt = state;
        if (flush_i) state_nxt = IDLE;
        else if (accept) state_nxt = EXEC;
        else if (xfer) state_nxt = IDLE;
        else if (state == EXEC && s1_ctrl == OP_MUL) state_nxt = MULW;
    end

    // Issue register: state plus captured op and operands
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            s1_ctrl <= OP_NONE;
            s1_d1   <= 32'd0;
            s1_d2   <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                s1_ctrl <= dec_ctrl;
                s1_d1   <= rs1_data_i;
                s1_d2   <= dec_d2;
            end
        end
    end

    // Result register: loads on transfer, empties when the consumer takes it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid  <= 1'b0;
            s2_result <= 32'd0;
            s2_flag   <= 1'b0;
            s2_op     <= 4'd0;
        end else if (xfer) begin
            s2_valid  <= 1'b1;
            s2_result <= alu_data_i;
            s2_flag   <= alu_flag_i;
            s2_op     <= s1_ctrl;
        end else if (out_ready_i) begin
            s2_valid  <= 1'b0;
        end
    end

    // One-cycle pulse for a handshaked instruction that does not decode
    always_ff @(posedge clk_i) begin
        if (rst_i) illegal_q <= 1'b0;
        else illegal_q <= hs && !dec_legal;
    end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed-vector bench for alu_issue with a behavioural ALU
module tb_alu_issue;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] instr_i = 32'd0;
    logic [31:0] rs1_data_i = 32'd0;
    logic [31:0] rs2_data_i = 32'd0;
    logic [31:0] data1_o, data2_o;
    logic [3:0]  ALUCtrl_o;
    logic [31:0] alu_data_i;
    logic        alu_flag_i;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] result_o;
    logic        flag_o;
    logic [3:0]  op_o;
    logic        flush_i = 1'b0;
    logic        illegal_o;
    logic [32:0] alu_wide;
    int          checks = 0;
    int          errors = 0;

    localparam logic [31:0] I_ADD  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] I_SUB  = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] I_AND  = {7'b0000000, 5'd2, 5'd1, 3'b111, 5'd3, 7'b0110011};
    localparam logic [31:0] I_OR   = {7'b0000000, 5'd2, 5'd1, 3'b110, 5'd3, 7'b0110011};
    localparam logic [31:0] I_MUL  = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] I_ADDI = {12'hFFF, 5'd1, 3'b000, 5'd3, 7'b0010011};
    localparam logic [31:0] I_SW   = {7'h7F, 5'd2, 5'd1, 3'b010, 5'h1C, 7'b0100011};

    always #5 clk_i = ~clk_i;

    alu_issue dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .instr_i(instr_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .data1_o(data1_o), .data2_o(data2_o), .ALUCtrl_o(ALUCtrl_o),
        .alu_data_i(alu_data_i), .alu_flag_i(alu_flag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
        .flag_o(flag_o), .op_o(op_o), .flush_i(flush_i), .illegal_o(illegal_o)
    );

    // Behavioural ALU driven by the issue stage
    always_comb begin
        alu_wide = {1'b0, data1_o} + {1'b0, data2_o};
        if (ALUCtrl_o == 4'b0001) alu_wide = {1'b0, data1_o} - {1'b0, data2_o};
        else if (ALUCtrl_o == 4'b0010) alu_wide = {1'b0, data1_o & data2_o};
        else if (ALUCtrl_o == 4'b0011) alu_wide = {1'b0, data1_o | data2_o};
        else if (ALUCtrl_o == 4'b0100) alu_wide = {1'b0, data1_o * data2_o};
    end
    assign alu_data_i = alu_wide[31:0];
    assign alu_flag_i = alu_wide[32];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %0h want 0", in_ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", out_valid_o); end
        checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL rst_illegal got %0h want 0", illegal_o); end
        checks++; if (result_o !== 32'd0) begin errors++; $display("FAIL rst_result got %0h want 0", result_o); end
        checks++; if (flag_o !== 1'b0) begin errors++; $display("FAIL rst_flag got %0h want 0", flag_o); end
        checks++; if (op_o !== 4'b0000) begin errors++; $display("FAIL rst_op got %0h want 0", op_o); end
        checks++; if (ALUCtrl_o !== 4'b1111) begin errors++; $display("FAIL rst_ctrl got %0h want f", ALUCtrl_o); end
        checks++; if (data2_o !== 32'd0) begin errors++; $display("FAIL rst_data2 got %0h want 0", data2_o); end
        rst_i = 1'b0;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %0h want 1", in_ready_o); end
    endtask

    task automatic test_add();
        out_ready_i = 1'b1;
        in_valid_i = 1'b1; instr_i = I_ADD; rs1_data_i = 32'd5; rs2_data_i = 32'd7;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL add_ready got %0h want 1", in_ready_o); end
        tick();
        in_valid_i = 1'b0; rs1_data_i = 32'd0; rs2_data_i = 32'd0;
        #1;
        checks++; if (ALUCtrl_o !== 4'b1000) begin errors++; $display("FAIL add_ctrl got %0h want 8", ALUCtrl_o); end
        checks++; if (data1_o !== 32'd5) begin errors++; $display("FAIL add_data1 got %0h want 5", data1_o); end
        checks++; if (data2_o !== 32'd7) begin errors++; $display("FAIL add_data2 got %0h want 7", data2_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL add_early_valid got %0h want 0", out_valid_o); end
        tick();
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL add_valid got %0h want 1", out_valid_o); end
        checks++; if (result_o !== 32'd12) begin errors++; $display("FAIL add_result got %0h want c", result_o); end
        checks++; if (op_o !== 4'b1000) begin errors++; $display("FAIL add_op got %0h want 8", op_o); end
        checks++; if (ALUCtrl_o !== 4'b1111) begin errors++; $display("FAIL add_s1_empty got %0h want f", ALUCtrl_o); end
        tick();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL add_drain got %0h want 0", out_valid_o); end
    endtask

    task automatic test_imm();
        in_valid_i = 1'b1; instr_i = I_ADDI; rs1_data_i = 32'd10;
        tick();
        instr_i = I_SW; rs1_data_i = 32'd100; rs2_data_i = 32'd55;
        #1;
        checks++; if (data2_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_data2 got %0h want ffffffff", data2_o); end
        checks++; if (ALUCtrl_o !== 4'b0000) begin errors++; $display("FAIL addi_ctrl got %0h want 0", ALUCtrl_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL addi_b2b_ready got %0h want 1", in_ready_o); end
        tick();
        in_valid_i = 1'b0;
        #1;
        checks++; if (data2_o !== 32'hFFFFFFFC) begin errors++; $display("FAIL sw_data2 got %0h want fffffffc", data2_o); end
        checks++; if (ALUCtrl_o !== 4'b0110) begin errors++; $display("FAIL sw_ctrl got %0h want 6", ALUCtrl_o); end
        checks++; if (result_o !== 32'd9 || out_valid_o !== 1'b1) begin errors++; $display("FAIL addi_result got %0h/%0h want 9/1", result_o, out_valid_o); end
        checks++; if (flag_o !== 1'b1) begin errors++; $display("FAIL addi_flag got %0h want 1", flag_o); end
        checks++; if (op_o !== 4'b0000) begin errors++; $display("FAIL addi_op got %0h want 0", op_o); end
        tick();
        checks++; if (result_o !== 32'd96 || out_valid_o !== 1'b1) begin errors++; $display("FAIL sw_result got %0h/%0h want 60/1", result_o, out_valid_o); end
        checks++; if (op_o !== 4'b0110) begin errors++; $display("FAIL sw_op got %0h want 6", op_o); end
        tick();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL imm_drain got %0h want 0", out_valid_o); end
    endtask

    task automatic test_back_to_back();
        in_valid_i = 1'b1; instr_i = I_MUL; rs1_data_i = 32'd6; rs2_data_i = 32'd7;
        tick();
        instr_i = I_SUB; rs1_data_i = 32'd9; rs2_data_i = 32'd4;
        #1;
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL mul_exec_ready got %0h want 0", in_ready_o); end
        checks++; if (ALUCtrl_o !== 4'b0100) begin errors++; $display("FAIL mul_ctrl got %0h want 4", ALUCtrl_o); end
        tick();
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL mul_mulw_ready got %0h want 1", in_ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL mul_early_valid got %0h want 0", out_valid_o); end
        tick();
        in_valid_i = 1'b0;
        #1;
        checks++; if (out_valid_o !== 1'b1 || result_o !== 32'd42) begin errors++; $display("FAIL mul_result got %0h/%0h want 1/2a", out_valid_o, result_o); end
        checks++; if (op_o !== 4'b0100) begin errors++; $display("FAIL mul_op got %0h want 4", op_o); end
        tick();
        checks++; if (out_valid_o !== 1'b1 || result_o !== 32'd5) begin errors++; $display("FAIL sub_result got %0h/%0h want 1/5", out_valid_o, result_o); end
        checks++; if (op_o !== 4'b0001) begin errors++; $display("FAIL sub_op got %0h want 1", op_o); end
        tick();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0h want 0", out_valid_o); end
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; instr_i = I_ADD; rs1_data_i = 32'd1; rs2_data_i = 32'd2;
        tick();
        instr_i = I_OR; rs1_data_i = 32'hF0; rs2_data_i = 32'h0F;
        tick();
        in_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (out_valid_o !== 1'b1 || result_o !== 32'd3) begin errors++; $display("FAIL bp_hold_s2 cyc %0d got %0h/%0h want 1/3", i, out_valid_o, result_o); end
            checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready cyc %0d got %0h want 0", i, in_ready_o); end
            checks++; if (ALUCtrl_o !== 4'b0011 || data1_o !== 32'hF0) begin errors++; $display("FAIL bp_hold_s1 cyc %0d got %0h/%0h want 3/f0", i, ALUCtrl_o, data1_o); end
            tick();
        end
        out_ready_i = 1'b1;
        #1;
        checks++; if (result_o !== 32'd3 || in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release got %0h/%0h want 3/1", result_o, in_ready_o); end
        tick();
        checks++; if (out_valid_o !== 1'b1 || result_o !== 32'hFF) begin errors++; $display("FAIL bp_second got %0h/%0h want 1/ff", out_valid_o, result_o); end
        checks++; if (op_o !== 4'b0011) begin errors++; $display("FAIL bp_second_op got %0h want 3", op_o); end
        tick();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain got %0h want 0", out_valid_o); end
    endtask

    task automatic test_flush();
        in_valid_i = 1'b1; instr_i = I_MUL; rs1_data_i = 32'd3; rs2_data_i = 32'd3;
        tick();
        in_valid_i = 1'b0; flush_i = 1'b1;
        tick();
        checks++; if (ALUCtrl_o !== 4'b1111) begin errors++; $display("FAIL flush_clear got %0h want f", ALUCtrl_o); end
        in_valid_i = 1'b1; instr_i = I_ADD; rs1_data_i = 32'd1; rs2_data_i = 32'd1;
        tick();
        checks++; if (ALUCtrl_o !== 4'b1111) begin errors++; $display("FAIL flush_block got %0h want f", ALUCtrl_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_no_out got %0h want 0", out_valid_o); end
        flush_i = 1'b0; instr_i = I_AND; rs1_data_i = 32'hF0; rs2_data_i = 32'h3C;
        tick();
        in_valid_i = 1'b0;
        #1;
        checks++; if (ALUCtrl_o !== 4'b0010 || out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_and_issue got %0h/%0h want 2/0", ALUCtrl_o, out_valid_o); end
        tick();
        checks++; if (out_valid_o !== 1'b1 || result_o !== 32'h30) begin errors++; $display("FAIL flush_and_result got %0h/%0h want 1/30", out_valid_o, result_o); end
        checks++; if (op_o !== 4'b0010) begin errors++; $display("FAIL flush_and_op got %0h want 2", op_o); end
        tick();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_drain got %0h want 0", out_valid_o); end
    endtask

    task automatic test_illegal();
        in_valid_i = 1'b1; instr_i = 32'hFFFFFFFF;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL ill_ready got %0h want 1", in_ready_o); end
        checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL ill_early got %0h want 0", illegal_o); end
        tick();
        in_valid_i = 1'b0;
        #1;
        checks++; if (illegal_o !== 1'b1) begin errors++; $display("FAIL ill_pulse got %0h want 1", illegal_o); end
        checks++; if (ALUCtrl_o !== 4'b1111 || in_ready_o !== 1'b1) begin errors++; $display("FAIL ill_no_capture got %0h/%0h want f/1", ALUCtrl_o, in_ready_o); end
        tick();
        checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL ill_one_cycle got %0h want 0", illegal_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL ill_no_out got %0h want 0", out_valid_o); end
    endtask

    task automatic test_reset_mid_mul();
        in_valid_i = 1'b1; instr_i = I_MUL; rs1_data_i = 32'd6; rs2_data_i = 32'd7;
        tick();
        in_valid_i = 1'b0;
        tick();
        checks++; if (ALUCtrl_o !== 4'b0100 || in_ready_o !== 1'b1) begin errors++; $display("FAIL rmul_mulw got %0h/%0h want 4/1", ALUCtrl_o, in_ready_o); end
        rst_i = 1'b1;
        tick();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rmul_valid got %0h want 0", out_valid_o); end
        checks++; if (ALUCtrl_o !== 4'b1111) begin errors++; $display("FAIL rmul_ctrl got %0h want f", ALUCtrl_o); end
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL rmul_ready got %0h want 0", in_ready_o); end
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rmul_no_out cyc %0d got %0h want 0", i, out_valid_o); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_illegal();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have ports: clk_i  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_i  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: in_valid_i  in  1 / in_ready_o  out  1  instruction handshake.
REQ-004 SHALL have ports: instr_i  in  32  RV32 instruction word; rs1_data_i, rs2_data_i  in  32  register operands.
REQ-005 SHALL have ports: data1_o, data2_o  out  32 and ALUCtrl_o  out  4, which drive the ALU operands and op code.
REQ-006 SHALL have ports: alu_data_i  in  32 and alu_flag_i  in  1, which carry the ALU result and ALU bit-32 flag.
REQ-007 SHALL have ports: out_valid_o  out  1 / out_ready_i  in  1  result handshake; result_o  out  32; flag_o  out  1; op_o  out  4.
REQ-008 SHALL have ports: flush_i  in  1  squash the issue stage; illegal_o  out  1  one-cycle pulse for an undecodable instruction.

Function
REQ-009 SHALL decode ALUCtrl as follows: R-type (opcode 0110011) funct7=0000000/funct3=000 -> 1000 add; 0100000/000 -> 0001 sub; 0000000/111 -> 0010 and; 0000000/110 -> 0011 or; 0000001/000 -> 0100 mul.
REQ-010 SHALL decode: opcode 0010011/funct3 000 -> 0000 addi; 0000011/010 -> 0101 lw; 0100011/010 -> 0110 sw.
REQ-011 SHALL select data2_o: rs2_data_i for R-type; sign-extended I-imm (instr[31:20]) for addi/lw; sign-extended S-imm ({instr[31:25],instr[11:7]}) for sw. data1_o SHALL be rs1_data_i in all cases.
REQ-012 SHALL treat any other encoding as illegal: no capture, illegal_o=1 in the cycle after the handshake, in_ready_o unaffected.
REQ-013 SHALL have two stages: S1 (issue register: valid, ALUCtrl, data1, data2) drives the ALU combinationally; S2 (result register: valid, result, flag, op) drives the out_* ports.
REQ-014 SHALL use the S1 FSM states IDLE, EXEC and MULW. Transitions:
- IDLE->EXEC on a legal accept.
- EXEC->MULW when op=0100.
- EXEC/MULW->(IDLE or EXEC) on transfer to S2.
REQ-015 SHALL hold mul in S1 for exactly 2 cycles (EXEC then MULW) before its result is eligible for capture (multicycle ALU path); all other ops SHALL be eligible in EXEC.
REQ-016 SHALL transfer S1->S2 when S1 is eligible and (S2 empty or out_ready_i=1); S2 SHALL capture alu_data_i, alu_flag_i and ALUCtrl.
REQ-017 SHALL drive in_ready_o = S1 empty or S1 transferring this cycle, giving back-to-back issue with no bubble for non-mul ops.
REQ-018 SHALL hold S1 and S2 contents and the ALU outputs constant while out_valid_o=1 and out_ready_i=0; no result SHALL be lost or duplicated.
REQ-019 SHALL have latency: accept at edge N -> out_valid_o at N+2 (non-mul) or N+3 (mul) with S2 empty and out_ready_i=1.
REQ-020 SHALL ensure flush_i=1 clears S1 (state->IDLE) and blocks any accept that cycle; S2 SHALL be unaffected; flush SHALL win over a simultaneous transfer.
REQ-021 SHALL drive ALUCtrl_o=1111, data1_o=0 and data2_o=0 while S1 is empty.

Reset
REQ-022 SHALL, on rst_i=1 at a clock edge, set:
- S1/S2 valid=0, FSM=IDLE;
- out_valid_o=0, illegal_o=0, result_o=0, flag_o=0, op_o=0000;
- ALUCtrl_o=1111.
REQ-023 SHALL make reset asserted mid-mul discard the operation, with no result emitted afterwards.
REQ-024 SHALL make in_ready_o=0 during reset and 1 in the first cycle after release.

Verification
REQ-025 SHALL cover: add x3,x1,x2 with rs1=5, rs2=7 -> ALUCtrl_o=1000, data2_o=7; out_valid_o at N+2 with result_o=12, op_o=1000.
REQ-026 SHALL cover: addi with imm=0xFFF and rs1=10 -> data2_o=0xFFFFFFFF, ALUCtrl_o=0000; sw with imm=-4 -> data2_o=0xFFFFFFFC, ALUCtrl_o=0110.
REQ-027 SHALL cover: mul with rs1=6, rs2=7 followed back-to-back by sub with 9-4 -> in_ready_o low for 1 cycle; results 42 at N+3 then 5 at N+4.
REQ-028 SHALL cover: out_ready_i=0 for 3 cycles with 2 ops issued -> both held, in_ready_o=0; on release, results delivered in order, none dropped.
REQ-029 SHALL cover: flush_i asserted the cycle after a mul is accepted -> no output; a following and 0xF0&0x3C -> result_o=0x30.
REQ-030 SHALL cover: instr_i=0xFFFFFFFF with in_valid_i=1 -> illegal_o pulse of 1 cycle, out_valid_o stays 0; rst_i during MULW -> out_valid_o=0 and ALUCtrl_o=1111 the next cycle.
